// File: rtl/hzd_ctrl_pkg.sv
// Shared core types for the issue-side hazard controller: result classes,
// shadow-slot payload and the initial ready distances per class.
package core;

  localparam int unsigned REG_W = 5;
  localparam int unsigned RDY_W = 3;

  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_EX   = 2'd1,
    RC_MEM  = 2'd2,
    RC_ASM  = 2'd3
  } rclass_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [RDY_W-1:0] rdy;
  } hzd_slot_t;

  localparam logic [RDY_W-1:0] RDY_EX  = RDY_W'(2);
  localparam logic [RDY_W-1:0] RDY_MEM = RDY_W'(3);
  localparam logic [RDY_W-1:0] RDY_ASM = RDY_W'(4);

  // Advances still needed before a freshly issued result reaches a bypass latch.
  function automatic logic [RDY_W-1:0] rc_rdy(input rclass_t rc);
    case (rc)
      RC_EX:   rc_rdy = RDY_EX;
      RC_MEM:  rc_rdy = RDY_MEM;
      RC_ASM:  rc_rdy = RDY_ASM;
      default: rc_rdy = '0;
    endcase
  endfunction

endpackage

// File: rtl/hzd_ctrl_match.sv
// Finds the youngest valid shadow slot writing a given source register and
// returns its remaining ready distance.
module hzd_match
  import core::*;
#(
  parameter int unsigned NUM_SLOTS = 5
) (
  input  hzd_slot_t [NUM_SLOTS-1:0] slots,
  input  logic      [REG_W-1:0]     src,
  output logic                      hit,
  output logic      [RDY_W-1:0]     rdy
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit = 1'b0;
    rdy = '0;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].rd == src)) begin
        hit = 1'b1;
        rdy = slots[k].rdy;
      end
    end
  end

endmodule

// File: rtl/hzd_ctrl.sv
// Issue-side hazard controller: shadows in-flight producers RD..WB, stalls ID
// when an operand cannot be forwarded by EX, and counts stalled advances.
module hzd_ctrl
  import core::*;
#(
  parameter int unsigned NUM_SLOTS = 5,
  parameter int unsigned EX_DIST   = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             id_valid,
  input  logic             id_has_rs1,
  input  logic             id_has_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_has_rd,
  input  logic [REG_W-1:0] id_rd,
  input  rclass_t          id_rc,
  input  logic             flush_ex,
  output logic             stall_id,
  output logic             rs1_hzd,
  output logic             rs2_hzd,
  output logic [CNT_W-1:0] stall_cnt
);

  hzd_slot_t [NUM_SLOTS-1:0] slots;
  hzd_slot_t [NUM_SLOTS-1:0] slots_nxt;
  hzd_slot_t                 issue_ent;
  logic                      hit1, hit2;
  logic      [RDY_W-1:0]     rdy1, rdy2;
  logic                      issue;

  hzd_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_rs1 (
    .slots (slots),
    .src   (id_rs1),
    .hit   (hit1),
    .rdy   (rdy1)
  );

  hzd_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_rs2 (
    .slots (slots),
    .src   (id_rs2),
    .hit   (hit2),
    .rdy   (rdy2)
  );

  // A flush kills ID, so it also masks any hazard the killed instruction sees.
  always_comb begin
    rs1_hzd  = !flush_ex && id_valid && id_has_rs1 && (id_rs1 != '0)
               && hit1 && (rdy1 > RDY_W'(EX_DIST));
    rs2_hzd  = !flush_ex && id_valid && id_has_rs2 && (id_rs2 != '0)
               && hit2 && (rdy2 > RDY_W'(EX_DIST));
    stall_id = rs1_hzd | rs2_hzd;
  end

  always_comb begin
    issue = id_valid && !stall_id && !flush_ex && id_has_rd
            && (id_rd != '0) && (id_rc != RC_NONE);
    issue_ent       = '0;
    issue_ent.valid = issue;
    issue_ent.rd    = issue ? id_rd : '0;
    issue_ent.rdy   = issue ? rc_rdy(id_rc) : '0;
  end

  // Shift on advance with saturating countdown; the flush kills whatever sits in RD.
  always_comb begin
    slots_nxt = slots;
    if (adv) begin
      for (int k = 1; k < int'(NUM_SLOTS); k++) begin
        slots_nxt[k]     = slots[k-1];
        slots_nxt[k].rdy = (slots[k-1].rdy == '0) ? '0 : slots[k-1].rdy - RDY_W'(1);
      end
      slots_nxt[0] = issue_ent;
      if (flush_ex) begin
        slots_nxt[1].valid = 1'b0;
      end
    end else if (flush_ex) begin
      slots_nxt[0].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else begin
      slots <= slots_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (adv && stall_id && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hzd_ctrl.sv
// Directed, table-driven bench for hzd_ctrl with hand-written hold and reset sequences.
module tb_hzd_ctrl;
  import core::*;

  logic        clk;
  logic        rst_n;
  logic        adv;
  logic        id_valid;
  logic        id_has_rs1;
  logic        id_has_rs2;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_has_rd;
  logic [4:0]  id_rd;
  rclass_t     id_rc;
  logic        flush_ex;
  logic        stall_id;
  logic        rs1_hzd;
  logic        rs2_hzd;
  logic [31:0] stall_cnt;

  int total;
  int bad;

  hzd_ctrl #(.NUM_SLOTS(5), .EX_DIST(2), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (adv),
    .id_valid   (id_valid),
    .id_has_rs1 (id_has_rs1),
    .id_has_rs2 (id_has_rs2),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_has_rd  (id_has_rd),
    .id_rd      (id_rd),
    .id_rc      (id_rc),
    .flush_ex   (flush_ex),
    .stall_id   (stall_id),
    .rs1_hzd    (rs1_hzd),
    .rs2_hzd    (rs2_hzd),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       adv;
    logic       vld;
    logic       h1;
    logic [4:0] rs1;
    logic       h2;
    logic [4:0] rs2;
    logic       hd;
    logic [4:0] rd;
    rclass_t    rc;
    logic       fl;
    logic       e_stall;
    logic       e_r1;
    logic       e_r2;
    int         e_cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic a, input logic v, input logic h1, input int r1,
                              input logic h2, input int r2, input logic hd, input int rd,
                              input rclass_t rc, input logic fl, input logic es,
                              input logic e1, input logic e2, input int ec);
    vec_t t;
    t.adv = a; t.vld = v; t.h1 = h1; t.rs1 = 5'(r1); t.h2 = h2; t.rs2 = 5'(r2);
    t.hd = hd; t.rd = 5'(rd); t.rc = rc; t.fl = fl;
    t.e_stall = es; t.e_r1 = e1; t.e_r2 = e2; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    adv = v.adv; id_valid = v.vld; id_has_rs1 = v.h1; id_rs1 = v.rs1;
    id_has_rs2 = v.h2; id_rs2 = v.rs2; id_has_rd = v.hd; id_rd = v.rd;
    id_rc = v.rc; flush_ex = v.fl;
  endtask

  // Drive one cycle, check combinational outputs and counter mid-cycle, then clock it.
  task automatic step(input vec_t v, input string name);
    drive(v);
    @(negedge clk);
    chk({name, ".stall_id"}, int'(stall_id), int'(v.e_stall));
    chk({name, ".rs1_hzd"},  int'(rs1_hzd),  int'(v.e_r1));
    chk({name, ".rs2_hzd"},  int'(rs2_hzd),  int'(v.e_r2));
    chk({name, ".stall_cnt"}, int'(stall_cnt), v.e_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, RC_NONE, 0, 0, 0, 0, 0));

    //        adv vld h1 rs1 h2 rs2 hd rd rc       fl stl r1 r2 cnt
    // back-to-back ALU
    tbl[0]  = mk(1, 1, 1, 1,  0, 0,  1, 5,  RC_EX,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 5,  1, 5,  1, 6,  RC_EX,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,  0, 0,  0, 0,  RC_NONE,0, 0, 0, 0, 0);
    // load-use: two stalls
    tbl[3]  = mk(1, 1, 1, 2,  0, 0,  1, 7,  RC_ASM, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 7,  1, 1,  1, 8,  RC_EX,  0, 1, 1, 0, 0);
    tbl[5]  = mk(1, 1, 1, 7,  1, 1,  1, 8,  RC_EX,  0, 1, 1, 0, 1);
    tbl[6]  = mk(1, 1, 1, 7,  1, 1,  1, 8,  RC_EX,  0, 0, 0, 0, 2);
    tbl[7]  = mk(1, 0, 0, 0,  0, 0,  0, 0,  RC_NONE,0, 0, 0, 0, 2);
    // load, independent op, use on rs2: one stall
    tbl[8]  = mk(1, 1, 1, 2,  0, 0,  1, 7,  RC_ASM, 0, 0, 0, 0, 2);
    tbl[9]  = mk(1, 1, 1, 3,  0, 0,  1, 10, RC_EX,  0, 0, 0, 0, 2);
    tbl[10] = mk(1, 1, 1, 1,  1, 7,  1, 11, RC_EX,  0, 1, 0, 1, 2);
    tbl[11] = mk(1, 1, 1, 1,  1, 7,  1, 11, RC_EX,  0, 0, 0, 0, 3);
    // MEM-class producer then consumer: one stall
    tbl[12] = mk(1, 1, 1, 1,  0, 0,  1, 12, RC_MEM, 0, 0, 0, 0, 3);
    tbl[13] = mk(1, 1, 1, 12, 0, 0,  1, 13, RC_EX,  0, 1, 1, 0, 3);
    tbl[14] = mk(1, 1, 1, 12, 0, 0,  1, 13, RC_EX,  0, 0, 0, 0, 4);
    // x0 is never tracked nor hazarded
    tbl[15] = mk(1, 1, 1, 1,  0, 0,  1, 0,  RC_ASM, 0, 0, 0, 0, 4);
    tbl[16] = mk(1, 1, 1, 0,  1, 0,  1, 13, RC_EX,  0, 0, 0, 0, 4);
    // flush kills load in RD and masks the would-be stall
    tbl[17] = mk(1, 1, 1, 1,  0, 0,  1, 9,  RC_ASM, 0, 0, 0, 0, 4);
    tbl[18] = mk(1, 1, 1, 9,  0, 0,  1, 14, RC_EX,  1, 0, 0, 0, 4);
    tbl[19] = mk(1, 1, 1, 9,  1, 9,  0, 0,  RC_NONE,0, 0, 0, 0, 4);
    // younger ALU result shadows an older load of the same register
    tbl[20] = mk(1, 1, 1, 1,  0, 0,  1, 15, RC_ASM, 0, 0, 0, 0, 4);
    tbl[21] = mk(1, 1, 1, 1,  0, 0,  1, 15, RC_EX,  0, 0, 0, 0, 4);
    tbl[22] = mk(1, 1, 1, 15, 0, 0,  0, 0,  RC_NONE,0, 0, 0, 0, 4);
    // younger load shadows an older ALU result
    tbl[23] = mk(1, 1, 1, 1,  0, 0,  1, 16, RC_EX,  0, 0, 0, 0, 4);
    tbl[24] = mk(1, 1, 1, 1,  0, 0,  1, 16, RC_ASM, 0, 0, 0, 0, 4);
    tbl[25] = mk(1, 1, 0, 0,  1, 16, 0, 0,  RC_NONE,0, 1, 0, 1, 4);
    tbl[26] = mk(1, 1, 0, 0,  1, 16, 0, 0,  RC_NONE,0, 1, 0, 1, 5);
    tbl[27] = mk(1, 1, 0, 0,  1, 16, 0, 0,  RC_NONE,0, 0, 0, 0, 6);

    // Reset state, with a consumer already presented in ID
    drive(mk(1, 1, 1, 5, 1, 6, 1, 5, RC_ASM, 0, 0, 0, 0, 0));
    #12;
    chk("reset.stall_id", int'(stall_id), 0);
    chk("reset.stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Load-use with a three-cycle advance hold in the middle of the stall
    step(mk(1, 1, 1, 1, 0, 0, 1, 7, RC_ASM, 0, 0, 0, 0, 6), "hold.lw");
    step(mk(1, 1, 1, 7, 0, 0, 1, 8, RC_EX,  0, 1, 1, 0, 6), "hold.s0");
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 1, 1, 7, 0, 0, 1, 8, RC_EX, 0, 1, 1, 0, 7), $sformatf("hold.frz%0d", i));
    end
    step(mk(1, 1, 1, 7, 0, 0, 1, 8, RC_EX,  0, 1, 1, 0, 7), "hold.s1");
    step(mk(1, 1, 1, 7, 0, 0, 1, 8, RC_EX,  0, 0, 0, 0, 8), "hold.go");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, RC_NONE,0, 0, 0, 0, 8), "hold.end");

    // Flush with adv low still clears RD and masks the stall
    step(mk(1, 1, 1, 1, 0, 0, 1, 20, RC_ASM, 0, 0, 0, 0, 8), "fl0.lw");
    step(mk(0, 1, 1, 20, 0, 0, 0, 0, RC_NONE, 1, 0, 0, 0, 8), "fl0.kill");
    step(mk(1, 1, 1, 20, 0, 0, 0, 0, RC_NONE, 0, 0, 0, 0, 8), "fl0.use");

    // Asynchronous reset in the middle of a load-use stall
    step(mk(1, 1, 1, 1, 0, 0, 1, 17, RC_ASM, 0, 0, 0, 0, 8), "rst.lw");
    drive(mk(1, 1, 1, 17, 0, 0, 1, 18, RC_EX, 0, 0, 0, 0, 0));
    #2;
    chk("rst.pre_stall", int'(stall_id), 1);
    rst_n = 1'b0;
    #1;
    chk("rst.stall_id", int'(stall_id), 0);
    chk("rst.rs1_hzd", int'(rs1_hzd), 0);
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 1, 1, 17, 0, 0, 1, 18, RC_EX, 0, 0, 0, 0, 0), "rst.use");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hzd_ctrl.md
# hzd_ctrl

Issue-side hazard controller for the bypass network. It keeps a shadow copy of every in-flight register producer in the RD, EX, MEM, ASM and WB stages, and counts down how many advances each one needs before its result reaches a bypass latch. It holds the instruction in ID when an operand it needs cannot be forwarded by the time that instruction reaches EX. It sits beside the bypass unit, between decode and the RD stage, and also exports a stall-cycle performance counter.

## Interface
Parameters:
- `NUM_SLOTS`, 5: shadow depth, covering RD, EX, MEM, ASM and WB.
- `EX_DIST`, 2: advances an instruction in ID needs to reach EX.
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `adv`  in  1  global pipeline advance for this cycle.
- `id_valid`  in  1  ID holds a real instruction.
- `id_has_rs1` / `id_has_rs2`  in  1  the instruction reads that source.
- `id_rs1` / `id_rs2`  in  5  source register indices.
- `id_has_rd`  in  1  the instruction writes a register.
- `id_rd`  in  5  destination register index.
- `id_rc`  in  2  result class, type `core::rclass_t`: `RC_NONE`, `RC_EX`, `RC_MEM`, `RC_ASM`.
- `flush_ex`  in  1  branch mispredict resolved in EX; kills RD and ID.
- `stall_id`  out  1  hold IF and ID, and insert a bubble into RD.
- `rs1_hzd` / `rs2_hzd`  out  1  per-source hazard flag.
- `stall_cnt`  out  `CNT_W`  count of stalled advance cycles.

## Operation
Slot contents:
- Each slot holds `{valid, rd[4:0], rdy[2:0]}`.
- Slot 0 is RD and slot 4 is WB.

Initial `rdy` on issue, taken from the result class:
- `RC_EX` = 2: the result is available from the EX/MEM latch.
- `RC_MEM` = 3: available from the MEM/ASM latch.
- `RC_ASM` = 4: available from ASM/WB. Loads use this class.
- `RC_NONE`: the issued entry is invalid.

Hazard detection:
- `hzdN` = `id_valid` && `id_has_rsN` && `rsN` != 0 && the youngest valid slot with `rd` == `rsN` has `rdy` > `EX_DIST`.
- Youngest means the lowest slot index.
- An older matching slot is ignored whenever a younger one matches, whatever its `rdy`.
- `stall_id` = `rs1_hzd` | `rs2_hzd`.
- All three outputs are combinational and are forced to 0 while `flush_ex` = 1.

Issue qualification:
- The ID instruction issues when `id_valid` && !`stall_id` && !`flush_ex` && `id_has_rd` && `id_rd` != 0 && `id_rc` != `RC_NONE`.
- Otherwise slot 0 receives a bubble.
- x0 is never tracked.

## Timing
Reset:
- All slots invalid, with `rd` = 0 and `rdy` = 0.
- `stall_cnt` = 0.
- All outputs read 0 while `rst_n` = 0.
- Reset asserted mid-stream drops every in-flight entry, and the counter restarts from 0.

When `adv` = 1, at the clock edge:
- Slot k+1 takes slot k.
- Slot 0 takes the issued entry or a bubble.
- Slot 4 retires; its value is in the regfile by the time a consumer would read it.
- Every shifted `rdy` decrements, saturating at 0.

When `adv` = 0:
- All slots hold.
- `stall_cnt` holds.
- `stall_id` may still assert; it is combinational and its value is only consumed on an advance.

Flush:
- `flush_ex` clears slot 0's `valid` in the same edge, whatever `adv` is.
- With `adv` = 1, slot 1 therefore receives an invalid entry.
- When `flush_ex` and a would-be `stall_id` coincide, the flush wins and `stall_id` = 0.

Counter and latency:
- `stall_cnt` increments on each edge where `adv` && `stall_id`, saturating at all ones.
- Stall latency from ID for a dependent consumer immediately behind its producer:
  - `RC_EX`: 0 cycles.
  - `RC_MEM`: 1 cycle.
  - `RC_ASM`: 2 cycles.
- Each independent instruction placed in between reduces the stall by 1.

## Structure
Package `core` adds:
- `rclass_t` and its encodings.
- `hzd_slot_t` = `{bool valid; logic [4:0] rd; logic [2:0] rdy}`.
- Constants `RDY_EX` = 2, `RDY_MEM` = 3, `RDY_ASM` = 4.

Sub-module `hzd_match`:
- Combinational, instantiated once per source.
- Inputs: the slot array and one source index.
- Outputs: `hit` and the youngest matching slot's `rdy`.

## Test plan
- Back-to-back ALU ops: `addi x5` (`RC_EX`) then `add x6,x5,x5`, with `adv` = 1 throughout -> `stall_id` = 0 every cycle and `stall_cnt` = 0.
- Load-use: `lw x7` (`RC_ASM`) then `add x8,x7,x1` -> `stall_id` = 1 for exactly 2 advance cycles, then the add issues and `stall_cnt` = 2.
- Load, one independent op, then a use of x7 -> 1 stall cycle. A `RC_MEM` producer followed directly by its consumer -> 1 stall cycle.
- x0 and flush:
  - `lw x0` then a read of x0 -> no stall.
  - `lw x9` in RD with `flush_ex` = 1, then a consumer of x9 -> no stall.
  - `rs2_hzd` reads 0 throughout both cases.
- Hold behaviour: a load-use stall with `adv` = 0 for 3 cycles mid-sequence -> slots and `stall_cnt` frozen, and the total remains 2 stall advances.
- Reset:
  - `rst_n` pulsed low asynchronously during a load-use stall -> `stall_id` = 0 immediately and `stall_cnt` = 0.
  - Afterwards, a consumer of the old load's rd issues without stall.
